// File: rtl/ca_feature_loader.sv
// ca_feature_loader: packs a serial stream of features into the classifier input bus, waits a settle window, then captures the result.
// Optional start-of-frame resync is enabled by defining CA_SOF_EN.
module ca_feature_loader #(
    parameter int WIDTH_A  = 4,
    parameter int NUM_A    = 21,
    parameter int OUTWIDTH = 22,
    parameter int SETTLE   = 4
) (
    input  logic                        clk,
    input  logic                        rst,
`ifdef CA_SOF_EN
    input  logic                        in_sof,
    output logic                        sof_err,
`endif
    input  logic                        in_valid,
    output logic                        in_ready,
    input  logic [WIDTH_A-1:0]          in_data,
    output logic [NUM_A*WIDTH_A-1:0]    inp,
    input  logic [OUTWIDTH-1:0]         out,
    output logic                        res_valid,
    input  logic                        res_ready,
    output logic [OUTWIDTH-1:0]         res_data,
    output logic                        busy
);
    localparam int IW = $clog2(NUM_A);
    localparam int CW = $clog2(SETTLE) + 1;
    localparam logic [IW-1:0] IDX_LAST = IW'(NUM_A - 1);
    localparam logic [CW-1:0] CNT_LAST = CW'(SETTLE - 1);

    typedef enum logic [1:0] {LOAD, SETL, HOLD} state_t;

    state_t                     state_q, state_d;
    logic [IW-1:0]              idx_q, idx_d;
    logic [CW-1:0]              cnt_q, cnt_d;
    logic [NUM_A*WIDTH_A-1:0]   inp_q, inp_d;
    logic [OUTWIDTH-1:0]        res_data_q, res_data_d;
    logic                       res_valid_q, res_valid_d;
    logic                       sof_err_q, sof_err_d;

    always_comb begin
        state_d     = state_q;
        idx_d       = idx_q;
        cnt_d       = cnt_q;
        inp_d       = inp_q;
        res_data_d  = res_data_q;
        res_valid_d = res_valid_q;
        sof_err_d   = sof_err_q;
        case (state_q)
            LOAD: if (in_valid) begin
`ifdef CA_SOF_EN
                // A start-of-frame beat resynchronises the frame without completing it.
                if (in_sof) begin
                    inp_d[WIDTH_A-1:0] = in_data;
                    idx_d              = IW'(1);
                    sof_err_d          = sof_err_q | (idx_q != '0);
                end else
`endif
                begin
                    inp_d[int'(idx_q)*WIDTH_A +: WIDTH_A] = in_data;
                    idx_d   = (idx_q == IDX_LAST) ? '0 : idx_q + IW'(1);
                    cnt_d   = '0;
                    state_d = (idx_q == IDX_LAST) ? SETL : LOAD;
                end
            end
            SETL: begin
                cnt_d = cnt_q + CW'(1);
                if (cnt_q == CNT_LAST) begin
                    res_data_d  = out;
                    res_valid_d = 1'b1;
                    state_d     = HOLD;
                end
            end
            HOLD: if (res_ready) begin
                res_valid_d = 1'b0;
                state_d     = LOAD;
            end
            default: state_d = LOAD;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= LOAD;
            idx_q       <= '0;
            cnt_q       <= '0;
            inp_q       <= '0;
            res_data_q  <= '0;
            res_valid_q <= 1'b0;
            sof_err_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            idx_q       <= idx_d;
            cnt_q       <= cnt_d;
            inp_q       <= inp_d;
            res_data_q  <= res_data_d;
            res_valid_q <= res_valid_d;
            sof_err_q   <= sof_err_d;
        end
    end

    assign in_ready  = state_q == LOAD;
    assign busy      = (state_q != LOAD) || (idx_q != '0);
    assign inp       = inp_q;
    assign res_data  = res_data_q;
    assign res_valid = res_valid_q;
`ifdef CA_SOF_EN
    assign sof_err   = sof_err_q;
`endif
endmodule

// File: tb/tb_ca_feature_loader.sv
// tb_ca_feature_loader: scoreboard bench for ca_feature_loader with a stand-in classifier model.
module tb_ca_feature_loader;
    localparam int SETTLE = 4;

    logic        clk = 0, rst = 1;
    logic        in_valid = 0, in_ready, in_sof_r = 0, sof_err;
    logic [3:0]  in_data = 0;
    logic [83:0] inp;
    logic [21:0] out, res_data;
    logic        res_valid, res_ready = 1, busy;

    int total = 0, bad = 0, n_push = 0, n_pop = 0;
    int cyc = 0, last_acc = 0;
    logic rv_prev = 0;
    logic [21:0] exp_q[$];
    logic [3:0] fr [21];

    function automatic logic [21:0] model(input logic [83:0] x);
        return x[21:0] ^ {x[42:22], x[43]} ^ x[65:44] ^ {4'b0, x[83:66]};
    endfunction

    function automatic logic [83:0] pack(input logic [3:0] f [21]);
        logic [83:0] p = '0;
        for (int i = 0; i < 21; i++) p[i*4 +: 4] = f[i];
        return p;
    endfunction

    assign out = model(inp);

    ca_feature_loader dut (
        .clk(clk), .rst(rst),
`ifdef CA_SOF_EN
        .in_sof(in_sof_r), .sof_err(sof_err),
`endif
        .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
        .inp(inp), .out(out), .res_valid(res_valid), .res_ready(res_ready),
        .res_data(res_data), .busy(busy)
    );
`ifndef CA_SOF_EN
    assign sof_err = 1'b0;
`endif

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string nm, input logic [83:0] act, input logic [83:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h want %h", nm, act, exp);
        end
    endtask

    // Monitor: latency from last accepted beat, and in-order result scoreboard.
    always @(negedge clk) begin
        if (rst) rv_prev = 0;
        else begin
            if (res_valid && !rv_prev) chk("latency", 84'(cyc - last_acc), 84'(SETTLE));
            if (res_valid && res_ready) begin
                n_pop++;
                if (exp_q.size() == 0) chk("unexpected result", {62'b0, res_data}, 84'hDEAD);
                else chk("res_data", {62'b0, res_data}, {62'b0, exp_q.pop_front()});
            end
            if (in_valid && in_ready) last_acc = cyc + 1;
            rv_prev = res_valid;
        end
    end

    task automatic sync();
        @(posedge clk); #1;
    endtask

    task automatic send_beat(input logic [3:0] v, input bit gap, input bit sof);
        int n = 0;
        if (gap && $urandom_range(0, 1) == 1) begin
            in_valid = 0;
            @(posedge clk); #1;
        end
        in_valid = 1; in_data = v; in_sof_r = sof;
        @(negedge clk);
        while (!in_ready && n < 100) begin @(negedge clk); n++; end
        if (!in_ready) chk("beat accept timeout", {83'b0, in_ready}, 84'd1);
        @(posedge clk); #1;
        in_valid = 0; in_sof_r = 0;
    endtask

    task automatic send_frame(input bit gap);
        sync();
        for (int i = 0; i < 21; i++) send_beat(fr[i], gap, 0);
        exp_q.push_back(model(pack(fr)));
        n_push++;
    endtask

    task automatic wait_res();
        int n = 0;
        @(negedge clk);
        while (!res_valid && n < 50) begin @(negedge clk); n++; end
        if (!res_valid) chk("result timeout", {83'b0, res_valid}, 84'd1);
    endtask

    initial begin
        logic [21:0] rd;
        repeat (2) @(negedge clk);
        chk("rst inp", inp, 84'd0);
        chk("rst res_valid", {83'b0, res_valid}, 84'd0);
        chk("rst res_data", {62'b0, res_data}, 84'd0);
        chk("rst busy", {83'b0, busy}, 84'd0);
        chk("rst in_ready", {83'b0, in_ready}, 84'd1);
        chk("rst sof_err", {83'b0, sof_err}, 84'd0);
        rst = 0;

        // Frame 1: 1..15,0..5 back-to-back with consumer ready.
        for (int i = 0; i < 21; i++) fr[i] = 4'(i + 1);
        send_frame(0);
        @(negedge clk);
        chk("settle in_ready", {83'b0, in_ready}, 84'd0);
        chk("settle busy", {83'b0, busy}, 84'd1);
        wait_res();
        chk("slot0", {80'b0, inp[3:0]}, 84'd1);
        chk("slot20", {80'b0, inp[83:80]}, 84'd5);
        chk("inp frame1", inp, pack(fr));
        chk("hold in_ready", {83'b0, in_ready}, 84'd0);
        @(negedge clk);
        chk("post-hs in_ready", {83'b0, in_ready}, 84'd1);
        chk("post-hs res_valid", {83'b0, res_valid}, 84'd0);
        chk("post-hs busy", {83'b0, busy}, 84'd0);

        // Same frame under back-pressure with beats offered during HOLD.
        res_ready = 0;
        send_frame(0);
        wait_res();
        rd = res_data;
        in_valid = 1; in_data = 4'hF;
        repeat (10) begin
            @(negedge clk);
            chk("bp res_valid", {83'b0, res_valid}, 84'd1);
            chk("bp res_data", {62'b0, res_data}, {62'b0, rd});
            chk("bp in_ready", {83'b0, in_ready}, 84'd0);
        end
        in_valid = 0;
        res_ready = 1;
        repeat (2) @(negedge clk);
        chk("bp release in_ready", {83'b0, in_ready}, 84'd1);
        chk("bp inp untouched", inp, pack(fr));

        // Three frames with random in_valid gaps.
        for (int k = 0; k < 3; k++) begin
            for (int i = 0; i < 21; i++) fr[i] = 4'((i * (3 + 2 * k) + 5 * k + 1) % 16);
            send_frame(1);
            wait_res();
            chk("gap inp", inp, pack(fr));
        end
        repeat (2) @(negedge clk);

        // Reset mid-frame, then a frame of all 7s.
        sync();
        for (int i = 0; i < 10; i++) send_beat(4'(i + 2), 0, 0);
        rst = 1;
        @(negedge clk);
        chk("midrst inp", inp, 84'd0);
        chk("midrst res_data", {62'b0, res_data}, 84'd0);
        chk("midrst busy", {83'b0, busy}, 84'd0);
        rst = 0;
        for (int i = 0; i < 21; i++) fr[i] = 4'd7;
        send_frame(0);
        chk("7s no stale res_valid", {83'b0, res_valid}, 84'd0);
        wait_res();
        chk("7s inp", inp, {21{4'd7}});
        repeat (2) @(negedge clk);

`ifdef CA_SOF_EN
        sync();
        for (int i = 0; i < 21; i++) begin
            fr[i] = 4'(15 - i);
            send_beat(fr[i], 0, i == 0);
        end
        exp_q.push_back(model(pack(fr))); n_push++;
        wait_res();
        chk("clean sof_err", {83'b0, sof_err}, 84'd0);
        repeat (2) @(negedge clk);
        sync();
        for (int i = 0; i < 5; i++) send_beat(4'(i + 1), 0, 0);
        fr[0] = 4'd9;
        send_beat(4'd9, 0, 1);
        for (int i = 1; i < 21; i++) begin
            fr[i] = 4'(i);
            send_beat(fr[i], 0, 0);
        end
        exp_q.push_back(model(pack(fr))); n_push++;
        wait_res();
        chk("sof slot0", {80'b0, inp[3:0]}, 84'd9);
        chk("sof inp", inp, pack(fr));
        chk("sof_err set", {83'b0, sof_err}, 84'd1);
        repeat (2) @(negedge clk);
`endif

        repeat (4) @(negedge clk);
        chk("queue drained", 84'(exp_q.size()), 84'd0);
        chk("result count", 84'(n_pop), 84'(n_push));
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
